// File: rtl/vesa_pkg.sv
// Shared definitions for the VESA test-pattern source: pattern codes, bar colours, pixel type.
package vesa_pkg;

    typedef logic [23:0] rgb_t;

    localparam logic [2:0] PAT_BARS     = 3'd0;
    localparam logic [2:0] PAT_GRID     = 3'd1;
    localparam logic [2:0] PAT_GRADIENT = 3'd2;
    localparam logic [2:0] PAT_SOLID    = 3'd3;
    localparam logic [2:0] PAT_CHECKER  = 3'd4;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000,  // 7 black
        24'h0000FF,  // 6 blue
        24'hFF0000,  // 5 red
        24'hFF00FF,  // 4 magenta
        24'h00FF00,  // 3 green
        24'h00FFFF,  // 2 cyan
        24'hFFFF00,  // 1 yellow
        24'hFFFFFF   // 0 white
    };

    function automatic rgb_t bar_color(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/vesa_pos_tracker.sv
// Local pixel position tracking from de_in/vsync_in: x, y, bar state and frame-start event.
module vesa_pos_tracker
    import vesa_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned X_W      = 12,
    parameter int unsigned Y_W      = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           de_in,
    input  logic           vsync_in,
    output logic           de_s1,
    output logic           vsync_s1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     bar_idx,
    output logic           frame_evt,
    output logic           frame_start
);

    localparam logic [X_W-1:0] X_MAX   = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] BAR_MAX = X_W'(H_ACTIVE / 8 - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_ACTIVE - 1);

    logic           de_q, vsync_q;
    logic [X_W-1:0] x_q, x_d;
    logic [X_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           fs_pipe_q, frame_start_q;
    logic           line_end;

    assign line_end  = de_q && !de_in;
    assign frame_evt = vsync_q && !vsync_in;

    // x/bar state describe the pixel currently held in stage 1.
    always_comb begin
        x_d       = x_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        y_d       = y_q;
        if (de_in && de_q) begin
            if (x_q != X_MAX) begin
                x_d = x_q + X_W'(1);
                if (bar_cnt_q == BAR_MAX) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + X_W'(1);
                end
            end
        end else begin
            x_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end
        // Frame-start wins over a coincident line end.
        if (frame_evt) begin
            y_d = '0;
        end else if (line_end && (y_q != Y_MAX)) begin
            y_d = y_q + Y_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            vsync_q       <= 1'b1;
            x_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            y_q           <= '0;
            fs_pipe_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_in;
            vsync_q       <= vsync_in;
            x_q           <= x_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            y_q           <= y_d;
            fs_pipe_q     <= frame_evt;
            frame_start_q <= fs_pipe_q;
        end
    end

    assign de_s1       = de_q;
    assign vsync_s1    = vsync_q;
    assign x           = x_q;
    assign y           = y_q;
    assign bar_idx     = bar_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/vesa_pattern_gen.sv
// Two-stage test-pattern source behind the VESA timing generator.
// Optional PATTERN_MOTION_EN: horizontal scroll of grid/gradient/checker by one pixel per frame.
module vesa_pattern_gen
    import vesa_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned X_W      = 12,
    parameter int unsigned Y_W      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [2:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    logic           de_s1, vsync_s1, hsync_s1_q;
    logic [X_W-1:0] x, x_eff;
    logic [Y_W-1:0] y;
    logic [2:0]     bar_idx;
    logic           frame_evt;

    logic [2:0]     sel_q;
    rgb_t           solid_q;
    rgb_t           pix;
    logic           hsync_q, vsync_q, de_q;
    rgb_t           rgb_q;

    vesa_pos_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_in       (de_in),
        .vsync_in    (vsync_in),
        .de_s1       (de_s1),
        .vsync_s1    (vsync_s1),
        .x           (x),
        .y           (y),
        .bar_idx     (bar_idx),
        .frame_evt   (frame_evt),
        .frame_start (frame_start)
    );

`ifdef PATTERN_MOTION_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_evt) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign x_eff = x + X_W'(frame_cnt_q);
`else
    assign x_eff = x;
`endif

    // Selection is only sampled at frame start so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (frame_evt) begin
            sel_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    always_comb begin
        pix = '0;
        case (sel_q)
            PAT_BARS: pix = bar_color(bar_idx);
            PAT_GRID: begin
                if ((x_eff[5:0] == 6'd0) || (y[5:0] == 6'd0) || (x_eff == X_MAX) || (y == Y_MAX)) begin
                    pix = 24'hFFFFFF;
                end
            end
            PAT_GRADIENT: pix = {x_eff[7:0], y[7:0], x_eff[7:0] + y[7:0]};
            PAT_SOLID:    pix = solid_q;
            PAT_CHECKER: begin
                if (x_eff[6] ^ y[6]) begin
                    pix = 24'hFFFFFF;
                end
            end
            default:      pix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_s1_q <= 1'b1;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            hsync_s1_q <= hsync_in;
            hsync_q    <= hsync_s1_q;
            vsync_q    <= vsync_s1;
            de_q       <= de_s1;
            rgb_q      <= de_s1 ? pix : '0;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign rgb   = rgb_q;

endmodule

// File: doc/vesa_pattern_gen.md
# vesa_pattern_gen

Test-pattern source placed directly downstream of the VESA timing generator. Consumes its `hsync`/`vsync`/`de` stream and produces 24-bit RGB pixels with sync and enable re-aligned. The output feeds the video output PHY or encoder. Pattern selection is latched once per frame so a frame is never torn.

## Interface
Parameters:
- `H_ACTIVE`, 1920: active pixels per line; must be a multiple of 8.
- `V_ACTIVE`, 1080: active lines per frame.
- `X_W`, 12: width of the x position counter.
- `Y_W`, 11: width of the y position counter.

Ports:
- `clk`  in  1  pixel clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `hsync_in`  in  1  horizontal sync from the timing generator; active-low.
- `vsync_in`  in  1  vertical sync from the timing generator; active-low.
- `de_in`  in  1  data enable from the timing generator.
- `pattern_sel`  in  3  pattern select: 0 bars, 1 grid, 2 gradient, 3 solid, 4 checker, 5–7 black.
- `solid_rgb`  in  24  colour for the solid pattern, {R,G,B}.
- `hsync`  out  1  `hsync_in` delayed 2 cycles.
- `vsync`  out  1  `vsync_in` delayed 2 cycles.
- `de`  out  1  `de_in` delayed 2 cycles.
- `rgb`  out  24  pixel {R[23:16], G[15:8], B[7:0]}.
- `frame_start`  out  1  1-cycle pulse, registered, on each vsync_in assertion edge.

## Operation
- Position tracking is done locally; no counters are taken from upstream.
- `x` increments on every `de_in`=1 cycle and clears to 0 on the cycle after `de_in` falls.
  - `x` saturates at H_ACTIVE-1 if `de_in` is held longer than H_ACTIVE.
- `y` increments on each falling edge of `de_in` and saturates at V_ACTIVE-1.
- Frame-start event = `vsync_in` 1→0. On this event:
  - `y` clears to 0;
  - `pattern_sel` and `solid_rgb` are latched into `sel_q`/`solid_q`;
  - `frame_start` pulses.
- Bars use a divider-free pair of counters:
  - `bar_cnt` counts 0..H_ACTIVE/8-1; at the end of its range `bar_idx` increments;
  - both clear with `x`.
- Bar colours by `bar_idx` 0..7: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Grid: FFFFFF when `x[5:0]`==0, `y[5:0]`==0, `x`==H_ACTIVE-1 or `y`==V_ACTIVE-1; otherwise 000000.
- Gradient: R=`x[7:0]`, G=`y[7:0]`, B=(`x`+`y`)[7:0], truncated modulo 256.
- Checker: FFFFFF when `x[6]`^`y[6]`=1, else 000000.
- Solid: `solid_q`.
- `rgb` is forced to 000000 whenever the output `de` is 0.
- Reset values:
  - `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `frame_start`=0;
  - `x`, `y`, `bar_cnt`, `bar_idx` all 0;
  - `sel_q`=0 (bars), `solid_q`=0.
- Reset asserted mid-frame: all state clears immediately. After release, output stays at idle levels until fresh input arrives. Until the first frame-start, `y` counts from 0 regardless of true position.

## Timing
- Fixed latency of 2 cycles, `*_in` → outputs, for sync, de and pixel alike.
  - Stage 1 registers inputs and position (`x`, `y`, bar state).
  - Stage 2 registers `rgb` and the delayed syncs.
- `frame_start` is asserted in the same cycle the delayed `vsync` first goes 0.
- A `pattern_sel` change takes effect on the first pixel after the next frame-start; it is never applied mid-frame.
- Frame-start and a `de_in` falling edge in the same cycle: the frame-start clear wins and `y`=0.

## Configuration
- `PATTERN_MOTION_EN` defined:
  - 8-bit `frame_cnt` increments on each frame-start and wraps 255→0;
  - grid, gradient and checker use `x_eff` = (`x` + `frame_cnt`) modulo 2^X_W in place of `x`, giving 1 px/frame horizontal scroll;
  - bars and solid are unaffected;
  - `frame_cnt` resets to 0.
- Undefined: no `frame_cnt` register; `x_eff`=`x`.

## Structure
- Shared package `vesa_pkg` holds:
  - pattern code constants (`PAT_BARS`..`PAT_CHECKER`);
  - the 8-entry bar colour table;
  - `rgb_t` (24-bit).
- One sub-module, `vesa_pos_tracker`: derives `x`, `y`, `bar_idx`, `frame_start` from `de_in`/`vsync_in`. Pattern muxing and output registers stay in the top module.

## Test plan
- Reset held, then released with idle inputs → `hsync`=`vsync`=1, `de`=0, `rgb`=000000.
- `pattern_sel`=0, full 1920x1080 frame → `rgb` per line is 240 px FFFFFF, then FFFF00 … 000000. First pixel appears exactly 2 cycles after the `de_in` rise.
- `pattern_sel`=2 → pixel (x=300, y=5) = {2C, 05, 31}; pixel (x=255, y=1) has B=00.
- `pattern_sel` changed 0→4 at line 500 → remainder of frame is still bars; next frame pixel (64,0)=FFFFFF and (0,0)=000000.
- `rst_n` pulsed low at line 200 → outputs return to reset values within the same cycle; the next frame after vsync renders correctly from y=0.
- `PATTERN_MOTION_EN` with `pattern_sel`=4 → in frame 1 (`frame_cnt`=1) pixel (63,0)=FFFFFF; without the macro it is 000000.
